// File: rtl/correlator_readout.sv
// Snapshots the correlator histogram on start, clears it, and streams a header + little-endian bin bytes; first byte 2 cycles after start.
// Holds tx_data/tx_valid and all counters while tx_ready=0; define CORRELATOR_READOUT_CHECKSUM_EN to append an XOR checksum byte.
module correlator_readout #(
   parameter int         MAX_DELAY  = 501,
   parameter int         RESOLUTION = 32,
   parameter logic [7:0] HEADER     = 8'hA5
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [RESOLUTION*MAX_DELAY-1:0]   hist_in,
   output logic                              hist_clear,
   output logic [7:0]                        tx_data,
   output logic                              tx_valid,
   input  logic                              tx_ready,
   output logic                              busy,
   output logic                              frame_done
);

   localparam int BYTES  = RESOLUTION / 8;
   localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int BIN_W  = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
   localparam int SNAP_W = RESOLUTION * MAX_DELAY;
   localparam int SEL_W  = $clog2(SNAP_W);

   localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(BYTES - 1);
   localparam logic [BIN_W-1:0]  BIN_MAX  = BIN_W'(MAX_DELAY - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CAPTURE = 3'd1;
   localparam logic [2:0] S_HEADER  = 3'd2;
   localparam logic [2:0] S_DATA    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd5;
`ifdef CORRELATOR_READOUT_CHECKSUM_EN
   localparam logic [2:0] S_CHECK   = 3'd4;
`endif

   logic [2:0]        r_state;
   logic [BYTE_W-1:0] r_byte_idx;
   logic [BIN_W-1:0]  r_bin_idx;
   logic [SNAP_W-1:0] r_snap;

   logic              w_xfer;
   logic              w_last;
   logic [SEL_W-1:0]  w_sel;
   logic [7:0]        w_byte;

   assign w_xfer = tx_valid & tx_ready;
   assign w_last = (r_byte_idx == BYTE_MAX) && (r_bin_idx == BIN_MAX);
   assign w_sel  = SEL_W'(r_bin_idx) * SEL_W'(RESOLUTION) + SEL_W'({r_byte_idx, 3'b000});
   assign w_byte = r_snap[w_sel +: 8];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_byte_idx <= '0;
         r_bin_idx  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_state    <= S_HEADER;
               r_byte_idx <= '0;
               r_bin_idx  <= '0;
            end
            S_HEADER: begin
               if (w_xfer) r_state <= S_DATA;
            end
            S_DATA: begin
               if (w_xfer) begin
                  if (w_last) begin
`ifdef CORRELATOR_READOUT_CHECKSUM_EN
                     r_state    <= S_CHECK;
`else
                     r_state    <= S_DONE;
`endif
                     r_byte_idx <= '0;
                     r_bin_idx  <= '0;
                  end else if (r_byte_idx == BYTE_MAX) begin
                     r_byte_idx <= '0;
                     r_bin_idx  <= r_bin_idx + BIN_W'(1);
                  end else begin
                     r_byte_idx <= r_byte_idx + BYTE_W'(1);
                  end
               end
            end
`ifdef CORRELATOR_READOUT_CHECKSUM_EN
            S_CHECK: begin
               if (w_xfer) r_state <= S_DONE;
            end
`endif
            // DONE is already idle from the host's view, so a new start is taken here
            S_DONE: begin
               r_state <= start ? S_CAPTURE : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Same edge as the correlator's clear: counts after this edge land in the next frame
   always_ff @(posedge clk) begin
      if (r_state == S_CAPTURE) r_snap <= hist_in;
   end

`ifdef CORRELATOR_READOUT_CHECKSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_csum <= '0;
      end else if (r_state == S_CAPTURE) begin
         r_csum <= '0;
      end else if (w_xfer && (r_state == S_HEADER || r_state == S_DATA)) begin
         r_csum <= r_csum ^ tx_data;
      end
   end
`endif

   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (r_state)
         S_HEADER: begin
            tx_valid = 1'b1;
            tx_data  = HEADER;
         end
         S_DATA: begin
            tx_valid = 1'b1;
            tx_data  = w_byte;
         end
`ifdef CORRELATOR_READOUT_CHECKSUM_EN
         S_CHECK: begin
            tx_valid = 1'b1;
            tx_data  = r_csum;
         end
`endif
         default: begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end
      endcase
   end

   assign hist_clear = (r_state == S_CAPTURE);
   assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
   assign frame_done = (r_state == S_DONE);

endmodule

// File: tb/tb_correlator_readout.sv
// Bench for correlator_readout with MAX_DELAY=3, RESOLUTION=16; expected bytes are queued at stimulus time and
// popped by a separate monitor on every accepted byte. Follows CORRELATOR_READOUT_CHECKSUM_EN like the design.
module tb_correlator_readout;

   localparam int MD  = 3;
   localparam int RES = 16;
`ifdef CORRELATOR_READOUT_CHECKSUM_EN
   localparam int FRAME_LEN = 1 + MD * RES / 8 + 1;
`else
   localparam int FRAME_LEN = 1 + MD * RES / 8;
`endif

   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic          start    = 1'b0;
   logic          tx_ready = 1'b1;
   logic [47:0]   hist_in  = '0;
   logic          hist_clear;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          busy;
   logic          frame_done;

   correlator_readout #(
      .MAX_DELAY  (MD),
      .RESOLUTION (RES),
      .HEADER     (8'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .hist_in    (hist_in),
      .hist_clear (hist_clear),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_clr    = 0;
   logic       toggle   = 1'b0;
   logic [7:0] exp_q[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Back-pressure source: ready alternates every cycle while toggle is set
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggle) tx_ready = ~tx_ready;
         else        tx_ready = 1'b1;
      end
   end

   // Monitor: samples on the falling edge, i.e. the state that the next rising edge will act on
   initial begin
      logic       hold;
      logic [7:0] hold_dat;
      hold     = 1'b0;
      hold_dat = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (hist_clear) n_clr++;
            if (hold) begin
               check("hold_valid", 32'(tx_valid), 32'd1);
               check("hold_stable", 32'(tx_data), 32'(hold_dat));
            end
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got %0h, required no byte", tx_data);
               end else begin
                  check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
               end
            end
            hold     = tx_valid && !tx_ready;
            hold_dat = tx_data;
         end else begin
            hold = 1'b0;
         end
      end
   end

   task automatic push_frame(input logic [47:0] h);
      logic [7:0] x;
      logic [7:0] b;
      x = 8'hA5;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < MD * 2; i++) begin
         b = h[i*8 +: 8];
         exp_q.push_back(b);
         x = x ^ b;
      end
`ifdef CORRELATOR_READOUT_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   task automatic run_frame(input logic [47:0] h, input logic tgl, input logic dbl_start);
      int k;
      int c0;
      push_frame(h);
      hist_in = h;
      c0      = n_clr;
      toggle  = tgl;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("clear_at_n1", 32'(hist_clear), 32'd1);
      check("busy_at_n1", 32'(busy), 32'd1);
      check("valid_at_n1", 32'(tx_valid), 32'd0);
      @(posedge clk); #1;
      hist_in = ~h;
      check("clear_at_n2", 32'(hist_clear), 32'd0);
      check("valid_at_n2", 32'(tx_valid), 32'd1);
      check("header_at_n2", 32'(tx_data), 32'h0000_00A5);
      k = 0;
      if (dbl_start) begin
         @(posedge clk); #1 k++;
         @(posedge clk); #1 k++;
         start = 1'b1;
         @(posedge clk); #1 k++;
         start = 1'b0;
      end
      while (!frame_done && k < 200) begin
         @(posedge clk); #1 k++;
      end
      check("frame_done_seen", 32'(frame_done), 32'd1);
      if (!tgl) check("frame_len", 32'(k), 32'(FRAME_LEN));
      check("busy_in_done", 32'(busy), 32'd0);
      check("valid_in_done", 32'(tx_valid), 32'd0);
      toggle = 1'b0;
      @(posedge clk); #1;
      check("frame_done_pulse", 32'(frame_done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("clear_count", 32'(n_clr - c0), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] h1;
      int          c0;
      h1 = {16'h0506, 16'h0304, 16'h0102};

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
      check("rst_clear", 32'(hist_clear), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // T1 basic, T2 back-pressure, T3 start while busy
      run_frame(h1, 1'b0, 1'b0);
      run_frame(h1, 1'b1, 1'b0);
      run_frame(h1, 1'b0, 1'b1);

      // T4 reset after the third accepted byte
      push_frame(h1);
      hist_in = h1;
      c0      = n_clr;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check("abort_valid", 32'(tx_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_clear", 32'(hist_clear), 32'd0);
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("abort_clear_count", 32'(n_clr - c0), 32'd1);
      check("abort_idle_valid", 32'(tx_valid), 32'd0);
      run_frame(h1, 1'b0, 1'b0);

      // T6 saturated bins
      run_frame({16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
